dff_bank_universal: RTL and testbench

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register bank with complementary outputs.
- Operating modes: hold, parallel D-load, per-bit toggle (T), shift, rotate and synchronous clear.
- Serial outputs allow banks to be chained.
- Serves as the general storage/shift element for datapath and counter blocks in the flip-flop library.

---
 rtl/dff_bank_universal.sv | 182 ++++++++++++++++++
 tb/tb_dff_bank_universal.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/dff_bank_universal.sv
// ---------------------------------------------------------------------------
// dff_bank_universal
//   WIDTH-bit register bank with complementary outputs. One bank can hold,
//   parallel-load, toggle bits under a mask, shift or rotate either way, and
//   clear to RESET_VAL. Registered serial outputs let banks be chained.
//
//   Ports
//     clk_i      clock, all state updates on the rising edge
//     rst_n_i    synchronous active-low reset (priority over en_i / mode_i)
//     en_i       mode-execute enable; 0 forces hold
//     mode_i     operation select (see dff_bank_pkg)
//     d_i        parallel data / toggle mask
//     sin_l_i    serial input into bit 0 on shift-left
//     sin_r_i    serial input into bit WIDTH-1 on shift-right
//     q_o        registered state
//     qbar_o     ~q_o (combinational, never a separate register)
//     sout_l_o   bit shifted out by the most recent SHL/ROL
//     sout_r_o   bit shifted out by the most recent SHR/ROR
//     changed_o  1 for one cycle when the last edge altered q
// ---------------------------------------------------------------------------

package dff_bank_pkg;
    localparam logic [2:0] MODE_HOLD   = 3'b000;
    localparam logic [2:0] MODE_LOAD   = 3'b001;
    localparam logic [2:0] MODE_TOGGLE = 3'b010;
    localparam logic [2:0] MODE_SHL    = 3'b011;
    localparam logic [2:0] MODE_SHR    = 3'b100;
    localparam logic [2:0] MODE_ROL    = 3'b101;
    localparam logic [2:0] MODE_ROR    = 3'b110;
    localparam logic [2:0] MODE_CLEAR  = 3'b111;
endpackage

// ---------------------------------------------------------------------------
// dff_bank_cell
//   One bit of the bank. The parent resolves which neighbour (or serial
//   input / wrap bit) feeds this bit for left and right moves, so the cell
//   only needs a single mux plus its flop.
//
//   Ports
//     clk_i, rst_n_i, en_i, mode_i  shared controls
//     d_i        this bit of the parallel data / toggle mask
//     left_in_i  value this bit takes on SHL/ROL
//     right_in_i value this bit takes on SHR/ROR
//     q_o        registered bit
//     q_d_o      next-state value (ignoring reset), used for change detect
// ---------------------------------------------------------------------------
module dff_bank_cell #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    input  logic [2:0] mode_i,
    input  logic       d_i,
    input  logic       left_in_i,
    input  logic       right_in_i,
    output logic       q_o,
    output logic       q_d_o
);
    import dff_bank_pkg::*;

    logic q_q;
    logic q_d;

    // d_i only reaches the flop in LOAD/TOGGLE, so an undriven d_i cannot
    // leak X into q in any other mode.
    always_comb begin
        q_d = q_q;
        if (en_i) begin
            unique case (mode_i)
                MODE_HOLD:            q_d = q_q;
                MODE_LOAD:            q_d = d_i;
                MODE_TOGGLE:          q_d = q_q ^ d_i;
                MODE_SHL, MODE_ROL:   q_d = left_in_i;
                MODE_SHR, MODE_ROR:   q_d = right_in_i;
                MODE_CLEAR:           q_d = RST_BIT;
                default:              q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) q_q <= RST_BIT;
        else          q_q <= q_d;
    end

    assign q_o   = q_q;
    assign q_d_o = q_d;
endmodule

// ---------------------------------------------------------------------------
// dff_bank_universal (top)
// ---------------------------------------------------------------------------
module dff_bank_universal #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             sin_l_i,
    input  logic             sin_r_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] qbar_o,
    output logic             sout_l_o,
    output logic             sout_r_o,
    output logic             changed_o
);
    import dff_bank_pkg::*;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] left_in;
    logic [WIDTH-1:0] right_in;

    logic sout_l_q, sout_l_d;
    logic sout_r_q, sout_r_d;
    logic changed_q, changed_d;

    // End bits: serial input for shifts, wrap bit for rotates.
    logic left_end, right_end;
    assign left_end  = (mode_i == MODE_ROL) ? q_q[WIDTH-1] : sin_l_i;
    assign right_end = (mode_i == MODE_ROR) ? q_q[0]       : sin_r_i;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_lo
            assign left_in[i] = left_end;
        end else begin : g_lo
            assign left_in[i] = q_q[i-1];
        end
        if (i == WIDTH-1) begin : g_hi
            assign right_in[i] = right_end;
        end else begin : g_hi
            assign right_in[i] = q_q[i+1];
        end

        dff_bank_cell #(
            .RST_BIT (RESET_VAL[i])
        ) u_cell (
            .clk_i      (clk_i),
            .rst_n_i    (rst_n_i),
            .en_i       (en_i),
            .mode_i     (mode_i),
            .d_i        (d_i[i]),
            .left_in_i  (left_in[i]),
            .right_in_i (right_in[i]),
            .q_o        (q_q[i]),
            .q_d_o      (q_d[i])
        );
    end

    always_comb begin
        sout_l_d = sout_l_q;
        sout_r_d = sout_r_q;
        if (en_i) begin
            if (mode_i == MODE_SHL || mode_i == MODE_ROL) sout_l_d = q_q[WIDTH-1];
            if (mode_i == MODE_SHR || mode_i == MODE_ROR) sout_r_d = q_q[0];
        end
        // q_d already equals q_q when en_i=0, so this covers hold too.
        changed_d = (q_d != q_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sout_l_q  <= 1'b0;
            sout_r_q  <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            sout_l_q  <= sout_l_d;
            sout_r_q  <= sout_r_d;
            changed_q <= changed_d;
        end
    end

    assign q_o       = q_q;
    assign qbar_o    = ~q_q;
    assign sout_l_o  = sout_l_q;
    assign sout_r_o  = sout_r_q;
    assign changed_o = changed_q;
endmodule

// File: tb/tb_dff_bank_universal.sv
module tb_dff_bank_universal;
    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;

    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, TOG = 3'b010, SHL = 3'b011,
                           SHR  = 3'b100, ROL  = 3'b101, ROR = 3'b110, CLR = 3'b111;

    logic         clk = 1'b0;
    logic         rst_n, en, sin_l, sin_r;
    logic [2:0]   mode;
    logic [W-1:0] d, q, qbar;
    logic         sout_l, sout_r, changed;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dff_bank_universal #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .en_i      (en),
        .mode_i    (mode),
        .d_i       (d),
        .sin_l_i   (sin_l),
        .sin_r_i   (sin_r),
        .q_o       (q),
        .qbar_o    (qbar),
        .sout_l_o  (sout_l),
        .sout_r_o  (sout_r),
        .changed_o (changed)
    );

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sl;
        logic       sr;
        logic [7:0] eq;
        logic       esl;
        logic       esr;
        logic       ech;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic e, logic [2:0] m, logic [7:0] dd, logic sl,
                                logic sr, logic [7:0] eq, logic esl, logic esr, logic ech);
        vec_t v;
        v.rst_n = r; v.en = e; v.mode = m; v.d = dd; v.sl = sl; v.sr = sr;
        v.eq = eq; v.esl = esl; v.esr = esr; v.ech = ech;
        return v;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 ns after the rising edge.
    task automatic step(vec_t v, string tag);
        @(negedge clk);
        rst_n = v.rst_n; en = v.en; mode = v.mode; d = v.d; sin_l = v.sl; sin_r = v.sr;
        @(posedge clk);
        #1;
        chk({tag, " q"},       q,              v.eq);
        chk({tag, " qbar"},    qbar,           ~v.eq);
        chk({tag, " sout_l"},  {7'd0, sout_l}, {7'd0, v.esl});
        chk({tag, " sout_r"},  {7'd0, sout_r}, {7'd0, v.esr});
        chk({tag, " changed"}, {7'd0, changed}, {7'd0, v.ech});
    endtask

    initial begin
        logic [7:0] exp_q;
        rst_n = 1'b0; en = 1'b0; mode = HOLD; d = '0; sin_l = 1'b0; sin_r = 1'b0;

        // Reset with LOAD FF pending, then release
        vecs.push_back(mk(0, 1, LOAD, 8'hFF, 0, 0, 8'hA5, 0, 0, 0));
        vecs.push_back(mk(0, 1, LOAD, 8'hFF, 0, 0, 8'hA5, 0, 0, 0));
        vecs.push_back(mk(1, 1, LOAD, 8'hFF, 0, 0, 8'hFF, 0, 0, 1));
        // LOAD / TOGGLE
        vecs.push_back(mk(1, 1, LOAD, 8'h3C, 0, 0, 8'h3C, 0, 0, 1));
        vecs.push_back(mk(1, 1, TOG,  8'h0F, 0, 0, 8'h33, 0, 0, 1));
        vecs.push_back(mk(1, 1, TOG,  8'h00, 0, 0, 8'h33, 0, 0, 0));
        vecs.push_back(mk(1, 1, LOAD, 8'h33, 0, 0, 8'h33, 0, 0, 0));
        // Shifts
        vecs.push_back(mk(1, 1, LOAD, 8'h81, 0, 0, 8'h81, 0, 0, 1));
        vecs.push_back(mk(1, 1, SHL,  8'h00, 1, 0, 8'h03, 1, 0, 1));
        vecs.push_back(mk(1, 1, SHR,  8'hFF, 1, 0, 8'h01, 1, 1, 1));
        vecs.push_back(mk(1, 1, SHR,  8'h00, 0, 1, 8'h80, 1, 1, 1));
        // 8 x ROL of 96
        vecs.push_back(mk(1, 1, LOAD, 8'h96, 0, 0, 8'h96, 1, 1, 1));
        vecs.push_back(mk(1, 1, ROL,  8'h00, 0, 0, 8'h2D, 1, 1, 1));
        vecs.push_back(mk(1, 1, ROL,  8'hFF, 1, 1, 8'h5A, 0, 1, 1));
        vecs.push_back(mk(1, 1, ROL,  8'h00, 0, 0, 8'hB4, 0, 1, 1));
        vecs.push_back(mk(1, 1, ROL,  8'h00, 0, 0, 8'h69, 1, 1, 1));
        vecs.push_back(mk(1, 1, ROL,  8'h00, 0, 0, 8'hD2, 0, 1, 1));
        vecs.push_back(mk(1, 1, ROL,  8'h00, 0, 0, 8'hA5, 1, 1, 1));
        vecs.push_back(mk(1, 1, ROL,  8'h00, 0, 0, 8'h4B, 1, 1, 1));
        vecs.push_back(mk(1, 1, ROL,  8'h00, 0, 0, 8'h96, 0, 1, 1));
        // ROR of 01, ROL of FF
        vecs.push_back(mk(1, 1, LOAD, 8'h01, 0, 0, 8'h01, 0, 1, 1));
        vecs.push_back(mk(1, 1, ROR,  8'h00, 0, 0, 8'h80, 0, 1, 1));
        vecs.push_back(mk(1, 1, LOAD, 8'hFF, 0, 0, 8'hFF, 0, 1, 1));
        vecs.push_back(mk(1, 1, ROL,  8'h00, 0, 0, 8'hFF, 1, 1, 0));
        // Enable low, then CLEAR and HOLD
        vecs.push_back(mk(1, 1, LOAD, 8'h12, 0, 0, 8'h12, 1, 1, 1));
        vecs.push_back(mk(1, 0, LOAD, 8'hEE, 0, 0, 8'h12, 1, 1, 0));
        vecs.push_back(mk(1, 0, SHR,  8'hEE, 1, 1, 8'h12, 1, 1, 0));
        vecs.push_back(mk(1, 0, LOAD, 8'hEE, 0, 0, 8'h12, 1, 1, 0));
        vecs.push_back(mk(1, 1, CLR,  8'hEE, 0, 0, 8'hA5, 1, 1, 1));
        vecs.push_back(mk(1, 1, CLR,  8'h00, 0, 0, 8'hA5, 1, 1, 0));
        vecs.push_back(mk(1, 1, HOLD, 8'hFF, 1, 1, 8'hA5, 1, 1, 0));

        foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

        // WIDTH shift-lefts of all-ones with sin_l=0 drain the bank to zero.
        step(mk(1, 1, LOAD, 8'hFF, 0, 0, 8'hFF, 1, 1, 1), "drain load");
        exp_q = 8'hFF;
        for (int k = 0; k < W; k++) begin
            exp_q = {exp_q[6:0], 1'b0};
            step(mk(1, 1, SHL, 8'h00, 0, 0, exp_q, 1, 1, 1), $sformatf("drain%0d", k));
        end

        // Reset in the middle of a shift sequence, then resume from RESET_VAL.
        step(mk(1, 1, LOAD, 8'h00, 0, 0, 8'h00, 1, 1, 0), "mid load");
        step(mk(1, 1, SHL,  8'h00, 1, 0, 8'h01, 0, 1, 1), "mid shl0");
        step(mk(1, 1, SHL,  8'h00, 1, 1, 8'h03, 0, 1, 1), "mid shl1");
        step(mk(0, 1, SHL,  8'h00, 1, 1, 8'hA5, 0, 0, 0), "mid rst");
        step(mk(1, 1, SHL,  8'h00, 0, 0, 8'h4A, 1, 0, 1), "mid shl2");
        step(mk(1, 1, SHL,  8'h00, 0, 0, 8'h94, 0, 0, 1), "mid shl3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
